// File: rtl/fetch_pkg.sv
// Shared types and helpers for the halfword program fetch queue.
package fetch_pkg;

  typedef logic [15:0] halfword_t;
  typedef logic [31:0] word_t;

  localparam int HW_PER_WORD = 2;

  // Pop request 3 means 2; never pop more than is presented.
  function automatic logic [1:0] clamp_pop(input logic [1:0] req, input logic [1:0] avail);
    logic [1:0] r;
    r = (req == 2'd3) ? 2'd2 : req;
    return (r > avail) ? avail : r;
  endfunction

endpackage

// File: rtl/fetch_hw_queue.sv
// Halfword FIFO accepting 0-2 writes and 0-2 reads per cycle, with synchronous clear.
module fetch_hw_queue
  import fetch_pkg::*;
#(
  parameter int QDEPTH = 8,
  parameter int CW     = $clog2(QDEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clr,
  input  logic [1:0]    i_wr_n,
  input  halfword_t     i_wr_d0,
  input  halfword_t     i_wr_d1,
  input  logic [1:0]    i_rd_n,
  output halfword_t     o_rd_d0,
  output halfword_t     o_rd_d1,
  output logic [CW-1:0] o_count
);

  localparam int AW = $clog2(QDEPTH);

  halfword_t       r_mem [QDEPTH];
  logic [AW-1:0]   r_rd_ptr;
  logic [AW-1:0]   r_wr_ptr;
  logic [CW-1:0]   r_count;
  logic [AW-1:0]   w_rd_ptr1;
  logic [AW-1:0]   w_wr_ptr1;

  assign w_rd_ptr1 = r_rd_ptr + AW'(1);
  assign w_wr_ptr1 = r_wr_ptr + AW'(1);

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n || i_clr) begin
      r_rd_ptr <= AW'(0);
      r_wr_ptr <= AW'(0);
      r_count  <= CW'(0);
    end else begin
      r_rd_ptr <= r_rd_ptr + AW'(i_rd_n);
      r_wr_ptr <= r_wr_ptr + AW'(i_wr_n);
      r_count  <= r_count + CW'(i_wr_n) - CW'(i_rd_n);
    end
  end

  // Storage needs no reset: reads are gated by the occupancy count.
  always_ff @(posedge clk) begin
    if (rst_n && !i_clr && (i_wr_n != 2'd0)) begin
      r_mem[r_wr_ptr] <= i_wr_d0;
      if (i_wr_n == 2'd2) begin
        r_mem[w_wr_ptr1] <= i_wr_d1;
      end
    end
  end

  assign o_rd_d0 = (r_count != CW'(0)) ? r_mem[r_rd_ptr]  : 16'h0000;
  assign o_rd_d1 = (r_count >= CW'(2)) ? r_mem[w_rd_ptr1] : 16'h0000;
  assign o_count = r_count;

endmodule

// File: rtl/fetch_queue_chk.sv
// Simulation checker: queue occupancy stays within bounds on every accepted update.
module fetch_queue_chk #(
  parameter int QDEPTH = 8,
  parameter int CW     = 4
) (
  input logic          clk,
  input logic          rst_n,
  input logic [CW-1:0] i_count,
  input logic [1:0]    i_wr_n,
  input logic [1:0]    i_rd_n
);

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    (int'(i_count) + int'(i_wr_n) - int'(i_rd_n) <= QDEPTH));

  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    ((i_rd_n <= 2'd2) && (CW'(i_rd_n) <= i_count)));

endmodule

// File: rtl/prog_fetch_queue.sv
// Program fetch front end: issues word reads, splits them into halfwords for the decoder.
module prog_fetch_queue
  import fetch_pkg::*;
#(
  parameter int                ADDR_W     = 14,
  parameter int                QDEPTH     = 8,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              rom_req,
  output logic [ADDR_W-2:0] rom_addr,
  input  word_t             rom_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr,
  input  logic [1:0]        ir_pop,
  output logic [1:0]        ir_avail,
  output halfword_t         ir0,
  output halfword_t         ir1,
  output logic [ADDR_W-1:0] ir_pc
);

  localparam int CW = $clog2(QDEPTH) + 1;
  localparam int SW = CW + 2;

  logic [ADDR_W-2:0] r_ptr;
  logic              r_skip;
  logic              r_inflight;
  logic [ADDR_W-1:0] r_pc;

  logic [CW-1:0]     w_count;
  logic [1:0]        w_avail;
  logic [1:0]        w_pop;
  logic              w_wr_en;
  logic [1:0]        w_wr_n;
  halfword_t         w_wr_d0;
  logic [SW-1:0]     w_need;
  logic              w_issue;

  assign w_avail = (w_count >= CW'(2)) ? 2'd2 : w_count[1:0];
  assign w_pop   = redirect ? 2'd0 : clamp_pop(ir_pop, w_avail);

  // A response landing during a redirect belongs to the old stream and is dropped.
  assign w_wr_en = r_inflight & ~redirect;
  assign w_wr_n  = !w_wr_en ? 2'd0 : (r_skip ? 2'd1 : 2'd2);
  assign w_wr_d0 = r_skip ? rom_rdata[31:16] : rom_rdata[15:0];

  // Reserve room for the word already in flight plus the one about to be requested.
  assign w_need  = SW'(w_count) - SW'(w_pop)
                 + (r_inflight ? SW'(HW_PER_WORD) : SW'(0))
                 + SW'(HW_PER_WORD);
  assign w_issue = rst_n & ~redirect & (w_need <= SW'(QDEPTH));

  assign rom_req  = w_issue;
  assign rom_addr = r_ptr;
  assign ir_avail = w_avail;
  assign ir_pc    = r_pc;

  // Fetch pointer, odd-halfword skip, in-flight tracking and decoder PC.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr      <= RESET_ADDR[ADDR_W-1:1];
      r_skip     <= RESET_ADDR[0];
      r_inflight <= 1'b0;
      r_pc       <= RESET_ADDR;
    end else if (redirect) begin
      r_ptr      <= redirect_addr[ADDR_W-1:1];
      r_skip     <= redirect_addr[0];
      r_inflight <= 1'b0;
      r_pc       <= redirect_addr;
    end else begin
      r_ptr      <= w_issue ? (r_ptr + (ADDR_W-1)'(1)) : r_ptr;
      r_skip     <= w_wr_en ? 1'b0 : r_skip;
      r_inflight <= w_issue;
      r_pc       <= r_pc + ADDR_W'(w_pop);
    end
  end

  fetch_hw_queue #(
    .QDEPTH (QDEPTH),
    .CW     (CW)
  ) u_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (redirect),
    .i_wr_n  (w_wr_n),
    .i_wr_d0 (w_wr_d0),
    .i_wr_d1 (rom_rdata[31:16]),
    .i_rd_n  (w_pop),
    .o_rd_d0 (ir0),
    .o_rd_d1 (ir1),
    .o_count (w_count)
  );

  fetch_queue_chk #(
    .QDEPTH (QDEPTH),
    .CW     (CW)
  ) u_chk (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_count (w_count),
    .i_wr_n  (w_wr_n),
    .i_rd_n  (w_pop)
  );

endmodule

// File: doc/prog_fetch_queue.md
PROG_FETCH_QUEUE -- requirements
Module: prog_fetch_queue

Interface
REQ-001 Parameter ADDR_W, default 14, meaning the width of the halfword program address.
REQ-002 Parameter QDEPTH, default 8, meaning the queue capacity in halfwords; it SHALL be a power of 2 and at least 4.
REQ-003 Parameter RESET_ADDR, default 0, meaning the halfword address fetched first after reset.
REQ-004 clk  in  1  single system clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  reset, synchronous and active-low.
REQ-006 rom_req  out  1  word fetch request to program memory.
REQ-007 rom_addr  out  ADDR_W-1  32-bit word address of the request.
REQ-008 rom_rdata  in  32  read data; returns exactly one cycle after rom_req; [15:0] is the lower halfword address.
REQ-009 redirect  in  1  branch/BX flush request.
REQ-010 redirect_addr  in  ADDR_W  halfword target address; bit 0 selects the odd halfword.
REQ-011 ir_pop  in  2  number of halfwords the decoder consumes this cycle (0, 1 or 2).
REQ-012 ir_avail  out  2  number of valid halfwords presented, equal to min(count, 2).
REQ-013 ir0  out  16  queue head halfword; 0 when ir_avail=0.
REQ-014 ir1  out  16  second halfword; 0 when ir_avail<2.
REQ-015 ir_pc  out  ADDR_W  halfword address of ir0.

Function
REQ-016 The queue SHALL hold halfwords in address order: ir0 is the oldest entry and ir1 the next; ir0, ir1 and ir_avail are combinational from the queue state.
REQ-017 Pops exceeding ir_avail SHALL be clamped to ir_avail, and the pop value 3 SHALL be treated as 2.
REQ-018 Issue rule: rom_req=1 when (count - pop) + 2*inflight + 2 <= QDEPTH, redirect=0, and rst_n=1; inflight is 1 if a request was made in the previous cycle and not killed.
REQ-019 On issue, the fetch word pointer SHALL increment by 1, wrapping at 2^(ADDR_W-1); rom_addr equals the pointer value before the increment.
REQ-020 Response from a request in cycle C: written at the end of cycle C+1 and visible from cycle C+2; it writes two halfwords, low halfword first, unless the skip flag is set.
REQ-021 Skip flag: when set, only rom_rdata[31:16] is written; the flag clears on that write.
REQ-022 A write and a pop in the same cycle SHALL both take effect: count_next = count + written - popped.
REQ-023 The queue SHALL never overflow; the issue rule guarantees this, and it is asserted in simulation.
REQ-024 ir_pc SHALL advance by the popped amount each cycle, wrapping at 2^ADDR_W.
REQ-025 Redirect in cycle N, required actions:
- ignore ir_pop;
- empty the queue at the end of N;
- drop any response arriving in N or N+1 from earlier requests;
- load pointer = redirect_addr[ADDR_W-1:1];
- set skip = redirect_addr[0];
- set ir_pc = redirect_addr.
REQ-026 Redirect latency: the first rom_req occurs in N+1, and ir_avail becomes nonzero in N+3.
REQ-027 Back-to-back redirects SHALL each restart per REQ-025; the last one wins.
REQ-028 With QDEPTH >= 8 and ir_pop=2 every cycle, steady state SHALL sustain one rom_req per cycle with ir_avail=2.

Reset
REQ-029 While rst_n=0 at a clock edge, the following SHALL be cleared:
- count=0 and inflight=0;
- rom_req=0, ir_avail=0, ir0=0, ir1=0;
- pointer = RESET_ADDR>>1, skip = RESET_ADDR[0], ir_pc = RESET_ADDR.
REQ-030 The first rom_req SHALL occur in the first cycle with rst_n=1, and a response pending at reset SHALL be dropped.
REQ-031 Reset asserted mid-operation SHALL override redirect, pop and response writes in that cycle.

Structure
REQ-032 Shared package fetch_pkg SHALL hold halfword_t (16 bits), word_t (32 bits) and the constant HW_PER_WORD = 2.
REQ-033 Sub-module fetch_hw_queue: a QDEPTH-entry halfword FIFO with 0–2 writes and 0–2 reads per cycle, synchronous clear, and count output; the top level holds the pointer, skip, inflight and issue logic.

Verification
REQ-034 Reset release, RESET_ADDR=0, ROM word k = {2k+1, 2k}, ir_pop=0 -> rom_addr 0,1,2,3 in cycles 0–3, then rom_req=0; count=8; ir0=0x0000, ir1=0x0001.
REQ-035 Steady ir_pop=2 from cycle 2 -> rom_req every cycle; ir_pc steps 0,2,4…; ir_avail=2 continuously after cycle 2.
REQ-036 Redirect to 0x0011 in cycle N -> rom_req with rom_addr=0x08 in N+1; at N+3 ir_avail=1, ir0=0x0011, ir_pc=0x0011; stale in-flight data is never visible.
REQ-037 ir_pop=1 alternating with 0 at a full queue -> no overflow; requests resume only when the free-space rule holds; ir_pc increments by 1 per pop.
REQ-038 Redirect in the same cycle as ir_pop=2 and a response write -> the queue is empty at N+1 and ir_pc=redirect_addr.
REQ-039 rst_n=0 for one cycle mid-stream -> all outputs zero next cycle, and fetch restarts at RESET_ADDR.
